// File: rtl/signed_bcd_display_pkg.sv
// Shared types and constants for the signed BCD display converter.
package signed_bcd_display_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Active-high {g,f,e,d,c,b,a} patterns; SEG7[n] renders digit n.
    localparam logic [6:0]       SEG_BLANK = 7'h00;
    localparam logic [9:0][6:0]  SEG7 = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                         7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD digit to a 7-segment pattern, with blanking and polarity select.
module bcd_to_seg7
    import signed_bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       active_low,
    output logic [6:0] seg
);

    logic [6:0] pat;

    // Look up the digit; non-decimal nibbles render blank.
    always_comb begin
        pat = SEG_BLANK;
        if (!blank && digit <= 4'd9)
            pat = SEG7[digit];
        seg = active_low ? ~pat : pat;
    end

endmodule

// File: rtl/signed_bcd_display.sv
// Signed binary to multi-digit 7-segment converter using a sequential
// double-dabble engine (one shift per clock).
module signed_bcd_display
    import signed_bcd_display_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic [3:0]       bcd [DIGITS-1:0],
    output logic [6:0]       seg [DIGITS-1:0]
);

    localparam int SW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);

    // The digit count must cover the largest magnitude, 2**(WIDTH-1).
    if (WIDTH < 2 || (64'd10 ** DIGITS) <= (64'd1 << (WIDTH - 1))) begin : g_param_check
        $fatal(1, "signed_bcd_display: DIGITS too small for WIDTH");
    end

    state_t           state;
    logic [SW-1:0]    scratch, adj, scratch_nx;
    logic [WIDTH-1:0] mag, mag_nx;
    logic [CW-1:0]    cnt;
    logic             sign_int;
    logic             shown;     // a result exists since reset; blanks all until then
    logic [DIGITS-1:0] blank;

    // Add-3 correction on every scratch nibble that would overflow when doubled.
    always_comb begin
        adj = scratch;
        for (int k = 0; k < DIGITS; k++)
            if (scratch[k*4 +: 4] >= 4'd5)
                adj[k*4 +: 4] = scratch[k*4 +: 4] + 4'd3;
    end

    assign {scratch_nx, mag_nx} = {adj, mag} << 1;

    // Control FSM and result registers; the final shift loads bcd directly
    // so the new digits appear in the same cycle as done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sign     <= 1'b0;
            sign_int <= 1'b0;
            shown    <= 1'b0;
            scratch  <= '0;
            mag      <= '0;
            cnt      <= '0;
            for (int i = 0; i < DIGITS; i++)
                bcd[i] <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag      <= data[WIDTH-1] ? -data : data;
                        sign_int <= data[WIDTH-1];
                        scratch  <= '0;
                        cnt      <= CW'(WIDTH);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nx;
                    mag     <= mag_nx;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        for (int i = 0; i < DIGITS; i++)
                            bcd[i] <= scratch_nx[(DIGITS-1-i)*4 +: 4];
                        sign  <= sign_int;
                        done  <= 1'b1;
                        shown <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Leading-zero blanking: digit i blanks when digits 0..i are all zero,
    // except the least significant digit so that zero shows a single "0".
    always_comb begin
        logic run;
        run   = 1'b1;
        blank = '0;
        for (int i = 0; i < DIGITS; i++) begin
            run      = run & (bcd[i] == 4'd0);
            blank[i] = !shown || (BLANK_LZ && run && (i < DIGITS - 1));
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_to_seg7 u_seg (
            .digit      (bcd[i]),
            .blank      (blank[i]),
            .active_low (SEG_ACTIVE_LOW),
            .seg        (seg[i])
        );
    end

endmodule

// File: tb/tb_signed_bcd_display.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop on done.
module tb_signed_bcd_display;

    logic clk, rst, start, start3;
    logic [7:0]  data;
    logic [11:0] data3;

    logic busy0, done0, sign0, busy1, done1, sign1, busy2, done2, sign2, busy3, done3, sign3;
    logic [3:0] bcd0 [2:0];
    logic [3:0] bcd1 [2:0];
    logic [3:0] bcd2 [2:0];
    logic [3:0] bcd3 [3:0];
    logic [6:0] seg0 [2:0];
    logic [6:0] seg1 [2:0];
    logic [6:0] seg2 [2:0];
    logic [6:0] seg3 [3:0];

    signed_bcd_display u0 (.clk(clk), .rst(rst), .start(start), .data(data),
        .busy(busy0), .done(done0), .sign(sign0), .bcd(bcd0), .seg(seg0));
    signed_bcd_display #(.BLANK_LZ(1'b0)) u1 (.clk(clk), .rst(rst), .start(start), .data(data),
        .busy(busy1), .done(done1), .sign(sign1), .bcd(bcd1), .seg(seg1));
    signed_bcd_display #(.SEG_ACTIVE_LOW(1'b1)) u2 (.clk(clk), .rst(rst), .start(start), .data(data),
        .busy(busy2), .done(done2), .sign(sign2), .bcd(bcd2), .seg(seg2));
    signed_bcd_display #(.WIDTH(12), .DIGITS(4)) u3 (.clk(clk), .rst(rst), .start(start3), .data(data3),
        .busy(busy3), .done(done3), .sign(sign3), .bcd(bcd3), .seg(seg3));

    typedef struct {
        logic [7:0]  d;
        logic [11:0] bcd;
        logic        sign;
        logic [20:0] sd, sn, sa;   // default, no-blanking, active-low segments
    } vec_t;
    typedef struct { vec_t v; int t; } exp_t;
    typedef struct { logic [15:0] bcd; logic sign; logic [27:0] sd; int t; } exp3_t;

    vec_t  vt [7];
    exp_t  q0 [$];
    exp3_t q3 [$];
    exp_t  e0;
    exp3_t e3;
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor for the three 8-bit instances.
    always @(negedge clk) begin
        if (rst && done0) begin
            chk("done_expected", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk("latency", cyc - e0.t, 9);
                chk("bcd", {bcd0[0], bcd0[1], bcd0[2]}, e0.v.bcd);
                chk("sign", sign0, e0.v.sign);
                chk("seg", {seg0[0], seg0[1], seg0[2]}, e0.v.sd);
                chk("seg_nolz", {seg1[0], seg1[1], seg1[2]}, e0.v.sn);
                chk("seg_actlow", {seg2[0], seg2[1], seg2[2]}, e0.v.sa);
                chk("variants_done_sign", {done1, done2, sign1, sign2},
                    {2'b11, e0.v.sign, e0.v.sign});
                chk("variants_bcd", {bcd1[0], bcd1[1], bcd1[2], bcd2[0], bcd2[1], bcd2[2]},
                    {e0.v.bcd, e0.v.bcd});
            end
        end
    end

    // Monitor for the 12-bit, 4-digit instance.
    always @(negedge clk) begin
        if (rst && done3) begin
            chk("w12_done_expected", 32'(q3.size() > 0), 32'd1);
            if (q3.size() > 0) begin
                e3 = q3.pop_front();
                chk("w12_latency", cyc - e3.t, 13);
                chk("w12_bcd", {bcd3[0], bcd3[1], bcd3[2], bcd3[3]}, e3.bcd);
                chk("w12_sign", sign3, e3.sign);
                chk("w12_seg", {seg3[0], seg3[1], seg3[2], seg3[3]}, e3.sd);
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 40 && (busy0 || busy3); k++) @(negedge clk);
        if (busy0 || busy3) chk("idle_timeout", {busy0, busy3}, 2'b00);
    endtask

    // Issue one 8-bit conversion; data changes afterwards must not matter.
    task automatic issue(input int i);
        wait_idle();
        start = 1'b1;
        data  = vt[i].d;
        q0.push_back('{vt[i], cyc});
        @(negedge clk);
        start = 1'b0;
        data  = ~vt[i].d;
    endtask

    task automatic issue3(input logic [11:0] d, input logic [15:0] b, input logic s,
                          input logic [27:0] sd);
        wait_idle();
        start3 = 1'b1;
        data3  = d;
        q3.push_back('{b, s, sd, cyc});
        @(negedge clk);
        start3 = 1'b0;
        data3  = ~d;
    endtask

    initial begin
        vt[0] = '{8'h7F, 12'h127, 1'b0, {7'h06,7'h5B,7'h07}, {7'h06,7'h5B,7'h07}, {7'h79,7'h24,7'h78}};
        vt[1] = '{8'h80, 12'h128, 1'b1, {7'h06,7'h5B,7'h7F}, {7'h06,7'h5B,7'h7F}, {7'h79,7'h24,7'h00}};
        vt[2] = '{8'hFB, 12'h005, 1'b1, {7'h00,7'h00,7'h6D}, {7'h3F,7'h3F,7'h6D}, {7'h7F,7'h7F,7'h12}};
        vt[3] = '{8'h00, 12'h000, 1'b0, {7'h00,7'h00,7'h3F}, {7'h3F,7'h3F,7'h3F}, {7'h7F,7'h7F,7'h40}};
        vt[4] = '{8'h0A, 12'h010, 1'b0, {7'h00,7'h06,7'h3F}, {7'h3F,7'h06,7'h3F}, {7'h7F,7'h79,7'h40}};
        vt[5] = '{8'h64, 12'h100, 1'b0, {7'h06,7'h3F,7'h3F}, {7'h06,7'h3F,7'h3F}, {7'h79,7'h40,7'h40}};
        vt[6] = '{8'h9D, 12'h099, 1'b1, {7'h00,7'h6F,7'h6F}, {7'h3F,7'h6F,7'h6F}, {7'h7F,7'h10,7'h10}};

        rst = 1'b0; start = 1'b0; start3 = 1'b0; data = '0; data3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy_done_sign", {busy0, done0, sign0, busy1, busy2, busy3}, 6'b0);
        chk("rst_bcd", {bcd0[0], bcd0[1], bcd0[2]}, 12'h000);
        chk("rst_seg", {seg0[0], seg0[1], seg0[2]}, 21'h0);
        chk("rst_seg_actlow", {seg2[0], seg2[1], seg2[2]}, 21'h1FFFFF);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) issue(i);

        // Starts during SHIFT and in the DONE cycle are ignored; the cycle after done accepts.
        issue(5);                       // returns at start cycle + 1
        repeat (2) @(negedge clk);      // start cycle + 3
        start = 1'b1; data = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);      // start cycle + 8
        start = 1'b1;
        @(negedge clk);                 // start cycle + 9 (DONE), start still high
        @(negedge clk);                 // cycle after done
        issue(4);

        // Mid-conversion reset discards the result; start with reset is refused.
        wait_idle();
        start = 1'b1; data = 8'h9D;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy_sign", {busy0, sign0}, 2'b00);
        chk("midrst_bcd", {bcd0[0], bcd0[1], bcd0[2]}, 12'h000);
        chk("midrst_seg", {seg0[0], seg0[1], seg0[2], seg1[0], seg1[1], seg1[2]}, 42'h0);
        chk("midrst_seg_actlow", {seg2[0], seg2[1], seg2[2]}, 21'h1FFFFF);
        start = 1'b1; data = 8'h7F;
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        chk("start_during_rst", busy0, 1'b0);
        repeat (15) @(negedge clk);
        issue(6);

        issue3(12'h800, 16'h2048, 1'b1, {7'h5B, 7'h3F, 7'h66, 7'h7F});
        issue3(12'h7FF, 16'h2047, 1'b0, {7'h5B, 7'h3F, 7'h66, 7'h07});

        for (int k = 0; k < 60 && (q0.size() + q3.size()) != 0; k++) @(negedge clk);
        chk("drain", q0.size() + q3.size(), 0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
